pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage: owns the registered PC and selects the next PC from sequential increment, absolute jump, forward jump, or a return-address stack (RAS). It generalises the combinational PC+4 adder with configurable width, increment and reset vector. It adds stall handling and a RAS of configurable depth for call/return prediction. The PC output drives instruction-memory addressing; `pc_4` feeds the link-register writeback path.

## Interface
- `WIDTH`, 32: PC width in bits.
- `INC`, 4: sequential increment, in bytes.
- `RESET_PC`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: RAS entries; a power of two, ≥2.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: hold all state this cycle.
- `jump` input 2: redirect code. 00 = none; 01 or 11 = `jump_add`; 10 = `jump_forward_add`.
- `jump_add` input WIDTH: absolute jump target.
- `jump_forward_add` input WIDTH: forwarded (branch-resolved) target.
- `call` input 1: push the return address (`pc_4`) onto the RAS.
- `ret` input 1: pop the RAS and redirect to the popped address.
- `pc` output WIDTH: current PC, registered.
- `pc_4` output WIDTH: `pc + INC`, combinational.
- `ras_count` output clog2(RAS_DEPTH)+1: valid RAS entries.
- `ras_empty` / `ras_full` output 1 each: `ras_count == 0` / `ras_count == RAS_DEPTH`.
- `ras_underflow` output 1: registered one-cycle pulse when `ret` is taken with an empty RAS.

## Operation
- **Reset** (asynchronous, immediate): `pc = RESET_PC`, RAS pointer = 0, `ras_count = 0`, `ras_underflow = 0`. RAS entry contents are don't-care.
- **Stall:** when `stall = 1`, `pc`, the RAS and `ras_count` hold, and `jump`/`call`/`ret` are ignored. Upstream keeps its requests asserted until a non-stalled cycle. `ras_underflow` is 0 on a stalled cycle.
- **Next-PC priority** (non-stalled cycle):
  1. `jump` is 01 or 11 → `jump_add`.
  2. `jump` is 10 → `jump_forward_add`.
  3. `ret` with `ras_count > 0` → RAS top.
  4. Otherwise → `pc_4`.
- `ret` while `jump != 00` is ignored: no pop, no underflow.
- `ret` with `ras_count = 0`: next PC = `pc_4`, count stays 0, and `ras_underflow` pulses on the next cycle.
- **Push** (`call = 1`): write `pc_4` at the top slot and advance the pointer modulo RAS_DEPTH.
  - Count increments, saturating at RAS_DEPTH.
  - When full, the oldest entry is silently overwritten (circular wrap).
  - `call` is independent of `jump`; a JAL asserts both.
- **Pop** (`ret` taken): read the top, retreat the pointer modulo RAS_DEPTH, decrement the count.
- **`call` and `ret` taken together:** the redirect uses the old top. The top slot is then replaced with `pc_4`; pointer and count are unchanged.
- **`call` with `ret` on an empty RAS:** a normal push, plus an underflow pulse.
- **Arithmetic:** all additions are modulo 2^WIDTH. `pc_4` wraps silently, e.g. 0xFFFFFFFC + 4 = 0x00000000.

## Timing
- `pc` updates on the rising `clk` edge following the cycle in which the selection inputs are sampled. Redirect latency is one cycle.
- `pc_4` is valid combinationally in the same cycle as `pc`.
- RAS read and write both take effect at the same edge that updates `pc`. A push in cycle N is poppable by a `ret` in cycle N+1.
- `ras_count`, `ras_empty` and `ras_full` reflect registered state.
- `ras_underflow` is high for exactly one cycle, following the offending `ret` cycle.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. The first post-reset `pc` is `RESET_PC`, and sequential stepping resumes on the first edge after `rst` deasserts.

## Test plan
- **Reset and sequential stepping:** `RESET_PC = 0x100`, no requests, 4 cycles → `pc` = 0x100, 0x104, 0x108, 0x10C. Asserting `rst` mid-cycle → `pc` = 0x100 immediately.
- **Jump priority:** `jump = 11` with `jump_add = 0x400`, `ret = 1`, RAS non-empty → `pc = 0x400`, `ras_count` unchanged. Next, `jump = 10` with `jump_forward_add = 0x80` → `pc = 0x80`.
- **Call/return round trip:** at `pc = 0x200`, assert `call` with `jump = 01` and `jump_add = 0x500` → `pc = 0x500`, `ras_count = 1`. Later, `ret` → `pc = 0x204`, `ras_count = 0`.
- **Overflow wrap** (`RAS_DEPTH = 4`): 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_full`, count 4. Four `ret`s yield 0x54, 0x44, 0x34, 0x24, then `ras_empty`.
- **Underflow and stall:** `ret` with an empty RAS at `pc = 0x300` → `pc = 0x304` and a single-cycle `ras_underflow`. `stall` held 3 cycles with `jump = 01` → `pc` frozen and no RAS change. Release → the jump is taken.
- **Simultaneous call+ret and wrap:** RAS top 0x60, `call` and `ret` at `pc = 0x700` → `pc = 0x60`, count unchanged, top now 0x704. Separately, `pc = 0xFFFFFFFC` with no request → `pc = 0x00000000`.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: registered PC, next-PC selection
// (sequential / absolute jump / forwarded jump / return-address stack) and a
// circular return-address stack used for call/return prediction.
module pc_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       INC       = 4,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic [1:0]                     jump,
  input  logic [WIDTH-1:0]               jump_add,
  input  logic [WIDTH-1:0]               jump_forward_add,
  input  logic                           call,
  input  logic                           ret,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_4,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // ptr_q names the next free slot; the top of stack sits one below it.
  logic [WIDTH-1:0] pc_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             underflow_q;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] ras_top;
  logic             ret_taken;
  logic             pop;
  logic             push;
  logic             underflow_d;
  logic [WIDTH-1:0] next_pc;

  assign pc            = pc_q;
  assign pc_4          = pc_q + WIDTH'(INC);
  assign ras_count     = count_q;
  assign ras_empty     = (count_q == '0);
  assign ras_full      = (count_q == CNT_W'(RAS_DEPTH));
  assign ras_underflow = underflow_q;

  // Decode the request: a return only counts when no jump redirects this cycle.
  always_comb begin
    top_idx     = ptr_q - 1'b1;
    ras_top     = ras_q[top_idx];
    ret_taken   = ret && (jump == 2'b00) && !stall;
    pop         = ret_taken && !ras_empty;
    push        = call && !stall;
    underflow_d = ret_taken && ras_empty;
  end

  // Next-PC priority: absolute jump, forwarded jump, RAS top, then pc_4.
  always_comb begin
    next_pc = pc_4;
    if (jump[0])       next_pc = jump_add;
    else if (jump[1])  next_pc = jump_forward_add;
    else if (pop)      next_pc = ras_top;
  end

  // PC, stack pointer, entry count and underflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ptr_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
      if (!stall) begin
        pc_q <= next_pc;
        if (push && !pop) begin
          ptr_q <= ptr_q + 1'b1;
          if (!ras_full) count_q <= count_q + 1'b1;
        end else if (pop && !push) begin
          ptr_q   <= ptr_q - 1'b1;
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

  // Stack storage: a simultaneous call+ret replaces the top in place,
  // otherwise a call writes the free slot (overwriting the oldest when full).
  always_ff @(posedge clk) begin
    if (push && pop)  ras_q[top_idx] <= pc_4;
    else if (push)    ras_q[ptr_q]   <= pc_4;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: RESET_PC = 0x100, RAS_DEPTH = 4.
module tb_pc_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [1:0]        jump;
  logic [WIDTH-1:0]  jump_add;
  logic [WIDTH-1:0]  jump_forward_add;
  logic              call;
  logic              ret;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  pc_4;
  logic [2:0]        ras_count;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_unit #(
    .WIDTH(WIDTH), .INC(4), .RESET_PC(32'h100), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_add(jump_add),
    .jump_forward_add(jump_forward_add), .call(call), .ret(ret),
    .pc(pc), .pc_4(pc_4), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump = 2'b00; call = 0; ret = 0;
  endtask

  // Absolute jump to a target, taking one edge.
  task automatic go(input logic [31:0] target);
    idle();
    jump = 2'b01; jump_add = target;
    step();
    idle();
  endtask

  initial begin
    rst = 1; jump_add = '0; jump_forward_add = '0;
    idle();
    #12;
    check("reset_pc", pc, 32'h100);
    check("reset_count", {29'd0, ras_count}, 0);
    check("reset_empty", {31'd0, ras_empty}, 1);
    check("reset_underflow", {31'd0, ras_underflow}, 0);
    rst = 0;

    // sequential stepping
    step(); check("seq_1", pc, 32'h104);
    step(); check("seq_2", pc, 32'h108);
    step(); check("seq_3", pc, 32'h10C);
    check("seq_pc4", pc_4, 32'h110);

    // asynchronous reset between edges
    rst = 1; #1;
    check("async_reset_pc", pc, 32'h100);
    #1 rst = 0;
    step(); check("post_reset_step", pc, 32'h104);

    // call/return round trip with JAL
    go(32'h200); check("goto_200", pc, 32'h200);
    call = 1; jump = 2'b01; jump_add = 32'h500;
    step(); idle();
    check("jal_pc", pc, 32'h500);
    check("jal_count", {29'd0, ras_count}, 1);
    step(); check("after_jal_seq", pc, 32'h504);
    ret = 1; step(); idle();
    check("ret_pc", pc, 32'h204);
    check("ret_count", {29'd0, ras_count}, 0);
    check("ret_empty", {31'd0, ras_empty}, 1);

    // jump priority over ret
    call = 1; step(); idle();                 // push 0x208 from pc 0x204
    check("push_plain_pc", pc, 32'h208);
    check("push_plain_count", {29'd0, ras_count}, 1);
    jump = 2'b11; jump_add = 32'h400; ret = 1; step(); idle();
    check("jump11_pc", pc, 32'h400);
    check("jump11_count", {29'd0, ras_count}, 1);
    check("jump11_no_uf", {31'd0, ras_underflow}, 0);
    jump = 2'b10; jump_forward_add = 32'h80; step(); idle();
    check("jump10_pc", pc, 32'h80);
    ret = 1; step(); idle();
    check("ret_after_jumps", pc, 32'h208);
    check("ret_after_jumps_cnt", {29'd0, ras_count}, 0);

    // overflow wrap: pushes 0x14,0x24,0x34,0x44,0x54
    go(32'h10);
    for (int i = 2; i <= 6; i++) begin
      call = 1; jump = 2'b01; jump_add = 32'(i * 16);
      step();
    end
    idle();
    check("ovf_pc", pc, 32'h60);
    check("ovf_count", {29'd0, ras_count}, 4);
    check("ovf_full", {31'd0, ras_full}, 1);
    ret = 1; step(); check("pop_1", pc, 32'h54);
    step(); check("pop_2", pc, 32'h44);
    step(); check("pop_3", pc, 32'h34);
    step(); check("pop_4", pc, 32'h24);
    idle();
    check("pop_empty", {31'd0, ras_empty}, 1);
    check("pop_not_full", {31'd0, ras_full}, 0);

    // underflow
    go(32'h300);
    ret = 1; step(); idle();
    check("uf_pc", pc, 32'h304);
    check("uf_pulse", {31'd0, ras_underflow}, 1);
    check("uf_count", {29'd0, ras_count}, 0);
    step();
    check("uf_clear", {31'd0, ras_underflow}, 0);
    check("uf_seq", pc, 32'h308);

    // stall holds everything, including a pending jump+call
    stall = 1; jump = 2'b01; jump_add = 32'h900; call = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h308);
      check("stall_count", {29'd0, ras_count}, 0);
    end
    stall = 0; step(); idle();
    check("release_pc", pc, 32'h900);
    check("release_count", {29'd0, ras_count}, 1);

    // simultaneous call+ret uses old top and replaces it
    go(32'h5C);
    call = 1; jump = 2'b01; jump_add = 32'h700; step(); idle();  // push 0x60
    check("pre_cr_pc", pc, 32'h700);
    check("pre_cr_count", {29'd0, ras_count}, 2);
    call = 1; ret = 1; step(); idle();
    check("cr_pc", pc, 32'h60);
    check("cr_count", {29'd0, ras_count}, 2);
    ret = 1; step(); check("cr_new_top", pc, 32'h704);
    step(); idle();
    check("cr_older", pc, 32'h30C);
    check("cr_empty", {31'd0, ras_empty}, 1);

    // modulo wrap of pc_4
    go(32'hFFFF_FFFC);
    check("wrap_pc4", pc_4, 32'h0);
    step(); check("wrap_pc", pc, 32'h0);

    // call+ret on an empty RAS: normal push plus underflow
    call = 1; ret = 1; step(); idle();
    check("cr_empty_pc", pc, 32'h4);
    check("cr_empty_count", {29'd0, ras_count}, 1);
    check("cr_empty_uf", {31'd0, ras_underflow}, 1);
    ret = 1; step(); idle();
    check("cr_empty_pop", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
